io_bus_initiator: RTL and testbench

//  Processor-side master for the KabIO register bus and the external interrupt handshake.

---
 rtl/io_bus_initiator_if.sv | 38 +++
 rtl/io_bus_initiator.sv | 137 +++++++++++++
 tb/tb_io_bus_initiator.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_initiator_if.sv
// KabIO initiator port bundle: CPU request/response, IO register bus and EIC interrupt handshake.
// The master modport is the initiator's view; slave is the environment (CPU, bus fabric, EIC).
interface io_bus_initiator_if #(
  parameter int INT_ID_W = 3
);
  logic                Req_Valid;
  logic                Req_Ready;
  logic                Req_Write;
  logic [29:0]         Req_Address;
  logic [31:0]         Req_WrData;
  logic                Resp_Valid;
  logic [31:0]         Resp_RdData;
  logic [29:0]         Sys_Address;
  logic                Sys_WrEn;
  logic                Sys_RdEn;
  logic [31:0]         Sys_WrData;
  logic [31:0]         Sys_RdData;
  logic                EIC_IntReq;
  logic [INT_ID_W-1:0] EIC_IntId;
  logic                EIC_IntAck;
  logic                Cpu_IntPending;
  logic [INT_ID_W-1:0] Cpu_IntId;
  logic                Cpu_IntTake;

  modport master (
    input  Req_Valid, Req_Write, Req_Address, Req_WrData, Sys_RdData,
    input  EIC_IntReq, EIC_IntId, Cpu_IntTake,
    output Req_Ready, Resp_Valid, Resp_RdData, Sys_Address, Sys_WrEn, Sys_RdEn, Sys_WrData,
    output EIC_IntAck, Cpu_IntPending, Cpu_IntId
  );

  modport slave (
    output Req_Valid, Req_Write, Req_Address, Req_WrData, Sys_RdData,
    output EIC_IntReq, EIC_IntId, Cpu_IntTake,
    input  Req_Ready, Resp_Valid, Resp_RdData, Sys_Address, Sys_WrEn, Sys_RdEn, Sys_WrData,
    input  EIC_IntAck, Cpu_IntPending, Cpu_IntId
  );
endinterface

// File: rtl/io_bus_initiator.sv
// Processor-side KabIO register-bus master (one transaction in flight, fixed read latency)
// plus the EIC interrupt acknowledge path with a post-ack holdoff window.
module io_bus_initiator #(
  parameter int RD_LATENCY  = 1,
  parameter int ACK_HOLDOFF = 2,
  parameter int INT_ID_W    = 3
) (
  input  logic          Sys_Clock,
  input  logic          Sys_Reset,
  io_bus_initiator_if.master bus
);

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;
  localparam int HOLD_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    RESP
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt, wait_nxt;
  logic [ADDR_W-1:0]   address, address_nxt;
  logic [DATA_W-1:0]   wr_data, wr_data_nxt;
  logic [DATA_W-1:0]   rd_data, rd_data_nxt;
  logic                wr_en, wr_en_nxt;
  logic                rd_en, rd_en_nxt;
  logic                resp_valid, resp_valid_nxt;

  logic [HOLD_W-1:0]   holdoff, holdoff_nxt;
  logic [INT_ID_W-1:0] int_id, int_id_nxt;
  logic                int_ack, int_ack_nxt;
  logic                hold_clear;
  logic                take;

  function automatic logic [HOLD_W-1:0] sat_dec(input logic [HOLD_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign hold_clear = (holdoff == '0);
  assign take       = bus.Cpu_IntTake & bus.Cpu_IntPending;

  // Bus sequencing: wait_cnt is preloaded so the last WAIT cycle is the RdData sample cycle.
  always_comb begin
    state_nxt      = state;
    wait_nxt       = wait_cnt;
    address_nxt    = address;
    wr_data_nxt    = wr_data;
    rd_data_nxt    = rd_data;
    wr_en_nxt      = 1'b0;
    rd_en_nxt      = 1'b0;
    resp_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Req_Valid) begin
          address_nxt = bus.Req_Address;
          if (bus.Req_Write) begin
            wr_data_nxt = bus.Req_WrData;
            wr_en_nxt   = 1'b1;
            state_nxt   = WRITE;
          end else begin
            rd_en_nxt = 1'b1;
            state_nxt = READ;
          end
        end
      end
      WRITE: state_nxt = IDLE;
      READ: begin
        wait_nxt  = CNT_W'(RD_LATENCY - 1);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          rd_data_nxt    = bus.Sys_RdData;
          resp_valid_nxt = 1'b1;
          state_nxt      = RESP;
        end else begin
          wait_nxt = wait_cnt - 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Interrupt path runs independently of the bus state machine.
  always_comb begin
    int_ack_nxt = take;
    holdoff_nxt = take ? HOLD_W'(ACK_HOLDOFF) : sat_dec(holdoff);
    int_id_nxt  = hold_clear ? bus.EIC_IntId : int_id;
  end

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      address    <= '0;
      wr_data    <= '0;
      rd_data    <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      resp_valid <= 1'b0;
      holdoff    <= '0;
      int_id     <= '0;
      int_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      address    <= address_nxt;
      wr_data    <= wr_data_nxt;
      rd_data    <= rd_data_nxt;
      wr_en      <= wr_en_nxt;
      rd_en      <= rd_en_nxt;
      resp_valid <= resp_valid_nxt;
      holdoff    <= holdoff_nxt;
      int_id     <= int_id_nxt;
      int_ack    <= int_ack_nxt;
    end
  end

  assign bus.Req_Ready      = (state == IDLE);
  assign bus.Resp_Valid     = resp_valid;
  assign bus.Resp_RdData    = rd_data;
  assign bus.Sys_Address    = address;
  assign bus.Sys_WrEn       = wr_en;
  assign bus.Sys_RdEn       = rd_en;
  assign bus.Sys_WrData     = wr_data;
  assign bus.EIC_IntAck     = int_ack;
  assign bus.Cpu_IntPending = bus.EIC_IntReq & hold_clear;
  assign bus.Cpu_IntId      = int_id;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Bench for io_bus_initiator: two instances (read latency 1 and 4) driven from transaction
// lists, with a reference register file and an abstract interrupt holdoff model.
module tb_io_bus_initiator;

  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_bus_initiator_if #(.INT_ID_W(3)) ifa ();
  io_bus_initiator_if #(.INT_ID_W(3)) ifb ();

  io_bus_initiator #(.RD_LATENCY(1), .ACK_HOLDOFF(HOLD), .INT_ID_W(3)) dut_a (
    .Sys_Clock(clk), .Sys_Reset(rst), .bus(ifa.master));
  io_bus_initiator #(.RD_LATENCY(4), .ACK_HOLDOFF(HOLD), .INT_ID_W(3)) dut_b (
    .Sys_Clock(clk), .Sys_Reset(rst), .bus(ifb.master));

  logic        req_valid [2];
  logic        req_write [2];
  logic [29:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        eic_req, take;
  logic [2:0]  eic_id;

  wire         req_ready  [2];
  wire         resp_valid [2];
  wire [31:0]  resp_rdata [2];
  wire [29:0]  sys_addr   [2];
  wire         sys_wr_en  [2];
  wire         sys_rd_en  [2];
  wire [31:0]  sys_wdata  [2];
  wire         ack  [2];
  wire         pend [2];
  wire [2:0]   cid  [2];

  logic [31:0] dev_mem [2][32];
  logic [31:0] ref_mem [2][32];
  logic        mem_sync;

  assign ifa.Req_Valid = req_valid[0];  assign ifb.Req_Valid = req_valid[1];
  assign ifa.Req_Write = req_write[0];  assign ifb.Req_Write = req_write[1];
  assign ifa.Req_Address = req_addr[0]; assign ifb.Req_Address = req_addr[1];
  assign ifa.Req_WrData = req_wdata[0]; assign ifb.Req_WrData = req_wdata[1];
  assign ifa.Sys_RdData = dev_mem[0][ifa.Sys_Address[4:0]];
  assign ifb.Sys_RdData = dev_mem[1][ifb.Sys_Address[4:0]];
  assign ifa.EIC_IntReq = eic_req;      assign ifb.EIC_IntReq = eic_req;
  assign ifa.EIC_IntId = eic_id;        assign ifb.EIC_IntId = eic_id;
  assign ifa.Cpu_IntTake = take;        assign ifb.Cpu_IntTake = take;

  assign req_ready[0] = ifa.Req_Ready;     assign req_ready[1] = ifb.Req_Ready;
  assign resp_valid[0] = ifa.Resp_Valid;   assign resp_valid[1] = ifb.Resp_Valid;
  assign resp_rdata[0] = ifa.Resp_RdData;  assign resp_rdata[1] = ifb.Resp_RdData;
  assign sys_addr[0] = ifa.Sys_Address;    assign sys_addr[1] = ifb.Sys_Address;
  assign sys_wr_en[0] = ifa.Sys_WrEn;      assign sys_wr_en[1] = ifb.Sys_WrEn;
  assign sys_rd_en[0] = ifa.Sys_RdEn;      assign sys_rd_en[1] = ifb.Sys_RdEn;
  assign sys_wdata[0] = ifa.Sys_WrData;    assign sys_wdata[1] = ifb.Sys_WrData;
  assign ack[0] = ifa.EIC_IntAck;          assign ack[1] = ifb.EIC_IntAck;
  assign pend[0] = ifa.Cpu_IntPending;     assign pend[1] = ifb.Cpu_IntPending;
  assign cid[0] = ifa.Cpu_IntId;           assign cid[1] = ifb.Cpu_IntId;

  // Register-file device on each bus; mem_sync reloads it from the reference copy.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_sync) begin
        for (int j = 0; j < 32; j++) dev_mem[d][j] <= ref_mem[d][j];
      end else if (sys_wr_en[d]) begin
        dev_mem[d][sys_addr[d][4:0]] <= sys_wdata[d];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic        tx_wr   [8];
  logic [29:0] tx_addr [8];
  logic [31:0] tx_data [8];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic sync_mem();
    @(negedge clk); mem_sync = 1'b1;
    @(negedge clk); mem_sync = 1'b0;
  endtask

  task automatic set_payload(input int d, input int i);
    req_valid[d] = 1'b1;
    req_write[d] = tx_wr[i];
    req_addr[d]  = tx_addr[i];
    req_wdata[d] = tx_data[i];
  endtask

  // Runs tx list 0..n-1 on DUT d; hold keeps Req_Valid asserted across transactions.
  task automatic run_seq(input int d, input int n, input bit hold);
    int dur;
    int guard;
    logic [3:0] exp_v, got_v;
    logic [31:0] exp_rd;
    exp_rd = '0;
    @(negedge clk);
    set_payload(d, 0);
    guard = 0;
    while (req_ready[d] !== 1'b1 && guard < 20) begin
      @(negedge clk); guard++;
    end
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (req_ready[d] !== 1'b1) begin
        n_bad++; $display("FAIL hs_ready dut%0d txn%0d: got %b want 1", d, i, req_ready[d]);
      end
      dur = tx_wr[i] ? 1 : 2 + lat(d);
      if (tx_wr[i]) ref_mem[d][tx_addr[i][4:0]] = tx_data[i];
      else exp_rd = ref_mem[d][tx_addr[i][4:0]];
      for (int k = 1; k <= dur; k++) begin
        @(negedge clk);
        if (k == 1) begin
          if (hold && i + 1 < n) set_payload(d, i + 1);
          else req_valid[d] = 1'b0;
          n_cmp++;
          if (sys_addr[d] !== tx_addr[i]) begin
            n_bad++; $display("FAIL sys_addr dut%0d txn%0d: got %h want %h", d, i, sys_addr[d], tx_addr[i]);
          end
          if (tx_wr[i]) begin
            n_cmp++;
            if (sys_wdata[d] !== tx_data[i]) begin
              n_bad++; $display("FAIL sys_wdata dut%0d txn%0d: got %h want %h", d, i, sys_wdata[d], tx_data[i]);
            end
          end
        end
        exp_v = {1'b0, tx_wr[i] && k == 1, !tx_wr[i] && k == 1, !tx_wr[i] && k == dur};
        got_v = {req_ready[d], sys_wr_en[d], sys_rd_en[d], resp_valid[d]};
        n_cmp++;
        if (got_v !== exp_v) begin
          n_bad++; $display("FAIL ctl{rdy,wr,rd,resp} dut%0d txn%0d cyc T+%0d: got %b want %b", d, i, k, got_v, exp_v);
        end
        if (!tx_wr[i] && k == dur) begin
          n_cmp++;
          if (resp_rdata[d] !== exp_rd) begin
            n_bad++; $display("FAIL resp_rdata dut%0d txn%0d: got %h want %h", d, i, resp_rdata[d], exp_rd);
          end
        end
      end
      @(negedge clk);
      if (!hold && i + 1 < n) set_payload(d, i + 1);
    end
    got_v = {req_ready[d], sys_wr_en[d], sys_rd_en[d], resp_valid[d]};
    n_cmp++;
    if (got_v !== 4'b1000) begin
      n_bad++; $display("FAIL idle_ctl dut%0d: got %b want 1000", d, got_v);
    end
    n_cmp++;
    if (sys_addr[d] !== tx_addr[n-1]) begin
      n_bad++; $display("FAIL addr_hold dut%0d: got %h want %h", d, sys_addr[d], tx_addr[n-1]);
    end
    if (!tx_wr[n-1]) begin
      n_cmp++;
      if (resp_rdata[d] !== exp_rd) begin
        n_bad++; $display("FAIL rdata_hold dut%0d: got %h want %h", d, resp_rdata[d], exp_rd);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({req_ready[d], sys_wr_en[d], sys_rd_en[d], resp_valid[d]} !== 4'b1000) begin
        n_bad++; $display("FAIL %s_ctl dut%0d: got %b want 1000", tag, d,
                          {req_ready[d], sys_wr_en[d], sys_rd_en[d], resp_valid[d]});
      end
      n_cmp++;
      if ({sys_addr[d], sys_wdata[d], resp_rdata[d]} !== 94'd0) begin
        n_bad++; $display("FAIL %s_data dut%0d: got %h %h %h want 0", tag, d, sys_addr[d], sys_wdata[d], resp_rdata[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; eic_req = 1'b0; take = 1'b0; eic_id = 3'd5;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    n_cmp++;
    if ({ack[0], pend[0], cid[0]} !== 5'b0) begin
      n_bad++; $display("FAIL reset_int: got %b want 00000", {ack[0], pend[0], cid[0]});
    end
    rst = 1'b0;
  endtask

  task automatic test_store();
    for (int d = 0; d < 2; d++) begin
      tx_wr[0] = 1'b1; tx_addr[0] = 30'h10; tx_data[0] = 32'hDEADBEEF;
      run_seq(d, 1, 1'b0);
    end
  endtask

  task automatic test_load();
    ref_mem[0][0] = 32'h1234; ref_mem[1][0] = 32'h1234;
    sync_mem();
    for (int d = 0; d < 2; d++) begin
      tx_wr[0] = 1'b0; tx_addr[0] = 30'h20; tx_data[0] = '0;
      run_seq(d, 1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        tx_wr[i] = 1'b0; tx_addr[i] = 30'($urandom); tx_data[i] = '0;
      end
      run_seq(d, 4, 1'b1);
    end
  endtask

  task automatic test_random_bus();
    int n;
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        tx_wr[i]   = $urandom_range(0, 1);
        tx_addr[i] = {25'($urandom), 5'($urandom_range(0, 7))};
        tx_data[i] = $urandom;
      end
      run_seq(r % 2, n, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_int_directed();
    take = 1'b0; eic_req = 1'b1; eic_id = 3'd7;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({pend[0], cid[0]} !== 4'b1111) begin
      n_bad++; $display("FAIL int_pre{pend,id}: got %b want 1111", {pend[0], cid[0]});
    end
    take = 1'b1;
    @(negedge clk);
    eic_id = 3'd2;
    n_cmp++;
    if ({ack[0], pend[0], cid[0]} !== 5'b10111) begin
      n_bad++; $display("FAIL int_T1{ack,pend,id}: got %b want 10111", {ack[0], pend[0], cid[0]});
    end
    @(negedge clk);
    n_cmp++;
    if ({ack[0], pend[0], cid[0]} !== 5'b00111) begin
      n_bad++; $display("FAIL int_T2{ack,pend,id}: got %b want 00111", {ack[0], pend[0], cid[0]});
    end
    @(negedge clk);
    take = 1'b0;
    n_cmp++;
    if ({ack[0], pend[0], cid[0]} !== 5'b01111) begin
      n_bad++; $display("FAIL int_T3{ack,pend,id}: got %b want 01111", {ack[0], pend[0], cid[0]});
    end
    @(negedge clk);
    n_cmp++;
    if ({ack[0], pend[0], cid[0]} !== 5'b01010) begin
      n_bad++; $display("FAIL int_T4{ack,pend,id}: got %b want 01010", {ack[0], pend[0], cid[0]});
    end
  endtask

  task automatic test_coincide();
    logic [31:0] data;
    data = $urandom;
    take = 1'b0; eic_req = 1'b1;
    repeat (4) @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 30'h44; req_wdata[0] = data;
    take = 1'b1;
    n_cmp++;
    if ({req_ready[0], pend[0]} !== 2'b11) begin
      n_bad++; $display("FAIL coin_pre{rdy,pend}: got %b want 11", {req_ready[0], pend[0]});
    end
    @(negedge clk);
    req_valid[0] = 1'b0; take = 1'b0;
    ref_mem[0][4] = data;
    n_cmp++;
    if ({sys_wr_en[0], ack[0], sys_wdata[0]} !== {2'b11, data}) begin
      n_bad++; $display("FAIL coin_T1{wr,ack,wdata}: got %b %b %h want 1 1 %h", sys_wr_en[0], ack[0], sys_wdata[0], data);
    end
    @(negedge clk);
    n_cmp++;
    if ({sys_wr_en[0], ack[0]} !== 2'b00) begin
      n_bad++; $display("FAIL coin_T2{wr,ack}: got %b want 00", {sys_wr_en[0], ack[0]});
    end
  endtask

  task automatic test_int_random();
    int m_hold;
    logic m_ack, m_pend, m_take;
    logic [2:0] m_id;
    logic [4:0] exp_v;
    take = 1'b0; eic_req = 1'b0; eic_id = 3'd3;
    repeat (6) @(negedge clk);
    m_hold = 0; m_ack = 1'b0; m_id = 3'd3;
    for (int c = 0; c < 200; c++) begin
      exp_v = {m_ack, eic_req && m_hold == 0, m_id};
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({ack[d], pend[d], cid[d]} !== exp_v) begin
          n_bad++; $display("FAIL int_rand dut%0d cyc%0d {ack,pend,id}: got %b want %b", d, c, {ack[d], pend[d], cid[d]}, exp_v);
        end
      end
      eic_req = ($urandom_range(0, 3) != 0);
      eic_id  = 3'($urandom);
      take    = 1'($urandom_range(0, 1));
      m_pend  = eic_req && m_hold == 0;
      m_take  = take && m_pend;
      if (m_hold == 0) m_id = eic_id;
      m_hold  = m_take ? HOLD : (m_hold > 0 ? m_hold - 1 : 0);
      m_ack   = m_take;
      @(negedge clk);
    end
    take = 1'b0; eic_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard;
    int seen;
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 30'($urandom);
    guard = 0;
    while (req_ready[1] !== 1'b1 && guard < 20) begin
      @(negedge clk); guard++;
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst_mid");
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL rst_mid_after: got %0d busy/resp cycles want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1; mem_sync = 1'b0;
    eic_req = 1'b0; take = 1'b0; eic_id = '0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      for (int j = 0; j < 32; j++) ref_mem[d][j] = $urandom;
    end
    test_reset();
    sync_mem();
    test_store();
    test_load();
    test_back_to_back();
    test_random_bus();
    test_int_directed();
    test_coincide();
    test_int_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
